// File: rtl/clk_rst_pkg.sv
// Shared types and default constants for the clock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_ARST,
    ST_HOLD,
    ST_RUN,
    ST_SOFT
  } state_e;

  localparam int CLK_RST_SYNC_STAGES_DEF = 2;
  localparam int CLK_RST_SRST_HOLD_DEF   = 16;
  localparam int CLK_RST_WDOG_CYCLES_DEF = 1024;

endpackage

// File: rtl/rst_sync.sv
// N-stage reset synchronizer: asserts asynchronously, releases on the STAGES-th edge.
// Provides the reset in both polarities plus a "released" flag, all straight from flops.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic rst_o,
  output logic rstn_o,
  output logic released_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("rst_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic              rst_q, rst_d;
  logic              rstn_q, rstn_d;

  // The polarity flops duplicate the last chain stage so every output is a register.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
    rst_d  = ~sync_q[STAGES-2];
    rstn_d = sync_q[STAGES-2];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '0;
      rst_q  <= 1'b1;
      rstn_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rst_q  <= rst_d;
      rstn_q <= rstn_d;
    end
  end

  assign rst_o      = rst_q;
  assign rstn_o     = rstn_q;
  assign released_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_gen.sv
// Reset sequencer: async-assert/sync-release arst, delayed srst, soft reset.
// Optional watchdog-triggered soft reset when CLK_RST_GEN_WDOG_EN is defined.
module clk_rst_gen
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES = CLK_RST_SYNC_STAGES_DEF,
  parameter int SRST_HOLD   = CLK_RST_SRST_HOLD_DEF,
  parameter int WDOG_CYCLES = CLK_RST_WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic sw_rst_req,
  output logic out_arst,
  output logic out_arstn,
  output logic out_srst,
  output logic out_srstn,
  output logic rst_done,
  output logic busy
`ifdef CLK_RST_GEN_WDOG_EN
  ,
  input  logic wdog_kick,
  output logic wdog_fired
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_rst_gen: SYNC_STAGES must be >= 2");
  end
  if (SRST_HOLD < 1) begin : g_bad_hold
    $error("clk_rst_gen: SRST_HOLD must be >= 1");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("clk_rst_gen: WDOG_CYCLES must be >= 2");
  end

  localparam int CW = $clog2(SRST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(SRST_HOLD);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v >= HOLD_C) ? HOLD_C : v + CW'(1);
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          srst_q, srst_d;
  logic          srstn_q, srstn_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          released;
  logic          soft_req;
  logic          cnt_step;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk),
    .arst      (arst),
    .rst_o     (out_arst),
    .rstn_o    (out_arstn),
    .released_o(released)
  );

`ifdef CLK_RST_GEN_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          fired_q, fired_d;
  logic          wdog_trip;

  // A kick in the same cycle as the terminal count wins over the trip.
  always_comb begin
    wdog_trip = (state_q == ST_RUN) && !wdog_kick && (wdog_q == WDOG_LAST);
    wdog_d    = '0;
    if ((state_q == ST_RUN) && !wdog_kick && !soft_req) begin
      wdog_d = wdog_q + WW'(1);
    end
    fired_d = fired_q | wdog_trip;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wdog_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fired_q <= fired_d;
    end
  end

  assign soft_req   = sw_rst_req | wdog_trip;
  assign wdog_fired = fired_q;
`else
  assign soft_req = sw_rst_req;
`endif

  assign cnt_inc = sat_inc(cnt_q);

  // Counting starts on the first edge after out_arst has dropped, whether the
  // FSM is still in ST_ARST or already in ST_HOLD/ST_SOFT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    srst_d   = srst_q;
    srstn_d  = srstn_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cnt_step = 1'b0;

    unique case (state_q)
      ST_ARST: cnt_step = released;
      ST_HOLD, ST_SOFT: begin
        if (soft_req) cnt_d = '0;
        else          cnt_step = 1'b1;
      end
      ST_RUN: begin
        if (soft_req) begin
          state_d = ST_SOFT;
          cnt_d   = '0;
          srst_d  = 1'b1;
          srstn_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_ARST;
    endcase

    if (cnt_step) begin
      cnt_d = cnt_inc;
      if (cnt_inc == HOLD_C) begin
        state_d = ST_RUN;
        srst_d  = 1'b0;
        srstn_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else if (state_q == ST_ARST) begin
        state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_ARST;
      cnt_q   <= '0;
      srst_q  <= 1'b1;
      srstn_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      srst_q  <= srst_d;
      srstn_q <= srstn_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out_srst  = srst_q;
  assign out_srstn = srstn_q;
  assign rst_done  = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed bench for clk_rst_gen: default instance (2/16) and a 3/1 instance.
// Watchdog checks are built only when CLK_RST_GEN_WDOG_EN is defined.
module tb_clk_rst_gen;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic sw1 = 1'b0;
  logic sw2 = 1'b0;
  logic a1, an1, s1, sn1, d1, b1;
  logic a2, an2, s2, sn2, d2, b2;
`ifdef CLK_RST_GEN_WDOG_EN
  logic kick1 = 1'b1;
  logic kick2 = 1'b1;
  logic fired1, fired2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_rst_gen #(.SYNC_STAGES(2), .SRST_HOLD(16), .WDOG_CYCLES(8)) dut1 (
    .clk(clk), .arst(arst), .sw_rst_req(sw1),
    .out_arst(a1), .out_arstn(an1), .out_srst(s1), .out_srstn(sn1),
    .rst_done(d1), .busy(b1)
`ifdef CLK_RST_GEN_WDOG_EN
    , .wdog_kick(kick1), .wdog_fired(fired1)
`endif
  );

  clk_rst_gen #(.SYNC_STAGES(3), .SRST_HOLD(1)) dut2 (
    .clk(clk), .arst(arst), .sw_rst_req(sw2),
    .out_arst(a2), .out_arstn(an2), .out_srst(s2), .out_srstn(sn2),
    .rst_done(d2), .busy(b2)
`ifdef CLK_RST_GEN_WDOG_EN
    , .wdog_kick(kick2), .wdog_fired(fired2)
`endif
  );

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_a1"}, a1, 1'b1);  check_val({tag, "_an1"}, an1, 1'b0);
    check_val({tag, "_s1"}, s1, 1'b1);  check_val({tag, "_sn1"}, sn1, 1'b0);
    check_val({tag, "_d1"}, d1, 1'b0);  check_val({tag, "_b1"}, b1, 1'b1);
    check_val({tag, "_a2"}, a2, 1'b1);  check_val({tag, "_an2"}, an2, 1'b0);
    check_val({tag, "_s2"}, s2, 1'b1);  check_val({tag, "_sn2"}, sn2, 1'b0);
    check_val({tag, "_d2"}, d2, 1'b0);  check_val({tag, "_b2"}, b2, 1'b1);
  endtask

  // arst is already low and the next posedge is edge 1 after release.
  task automatic power_seq(input string tag);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      check_val({tag, "_arst1"},  a1,  e < 2);
      check_val({tag, "_arstn1"}, an1, !(e < 2));
      check_val({tag, "_srst1"},  s1,  e < 18);
      check_val({tag, "_srstn1"}, sn1, !(e < 18));
      check_val({tag, "_done1"},  d1,  e == 18);
      check_val({tag, "_busy1"},  b1,  e < 18);
      check_val({tag, "_arst2"},  a2,  e < 3);
      check_val({tag, "_arstn2"}, an2, !(e < 3));
      check_val({tag, "_srst2"},  s2,  e < 4);
      check_val({tag, "_srstn2"}, sn2, !(e < 4));
      check_val({tag, "_done2"},  d2,  e == 4);
      check_val({tag, "_busy2"},  b2,  e < 4);
    end
  endtask

  // second_at > 0 issues a second request at k+second_at.
  task automatic soft_seq(input string tag, input int second_at);
    int hold_end;
    hold_end = (second_at > 0) ? second_at + 16 : 16;
    @(posedge clk); #1;
    sw1 = 1'b1;
    for (int j = 0; j <= hold_end + 1; j++) begin
      @(posedge clk); #1;
      check_val({tag, "_srst"},  s1,  j < hold_end);
      check_val({tag, "_srstn"}, sn1, !(j < hold_end));
      check_val({tag, "_done"},  d1,  j == hold_end);
      check_val({tag, "_busy"},  b1,  j < hold_end);
      check_val({tag, "_arst"},  a1,  1'b0);
      check_val({tag, "_arstn"}, an1, 1'b1);
      sw1 = (second_at > 0) && (j == second_at - 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset held for 5 cycles, released mid-cycle
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("por_hold");
    @(negedge clk) arst = 1'b0;
    power_seq("por");

    soft_seq("soft", 0);
    soft_seq("ext", 10);

    // Assert arst in the middle of ST_HOLD
    @(negedge clk) arst = 1'b1;
    @(negedge clk) arst = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check_val("mid_pre_arst", a1, 1'b0);
    check_val("mid_pre_srst", s1, 1'b1);
    #1 arst = 1'b1;
    #1;
    check_reset_vals("mid_arst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("mid_hold");
    @(negedge clk) arst = 1'b0;
    power_seq("mid_rel");

    // Sub-cycle glitch on arst while running
    @(posedge clk);
    #2 arst = 1'b1;
    #2 arst = 1'b0;
    #1;
    check_reset_vals("glitch");
    power_seq("glitch_rel");

`ifdef CLK_RST_GEN_WDOG_EN
    // Watchdog expiry: no kick for 8 cycles in ST_RUN
    @(posedge clk); #1;
    kick1 = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      @(posedge clk); #1;
      check_val("wdog_srst",  s1,     (j >= 8) && (j < 24));
      check_val("wdog_done",  d1,     j == 24);
      check_val("wdog_fired", fired1, j >= 8);
      check_val("wdog_arst",  a1,     1'b0);
      if (j == 24) kick1 = 1'b1;
    end
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      check_val("kick_srst",  s1,     1'b0);
      check_val("kick_fired", fired1, 1'b1);
      kick1 = (j % 5 == 0);
    end
    kick1 = 1'b1;
    @(negedge clk) arst = 1'b1;
    #1;
    check_val("wdog_clr_fired", fired1, 1'b0);
    check_reset_vals("wdog_arst");
    @(negedge clk) arst = 1'b0;
    power_seq("wdog_rel");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
